// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

   localparam int DATA_WIDTH = 16;

   // Quotient reported when the divisor is zero.
   localparam logic [DATA_WIDTH-1:0] DIV_ZERO_QUOT = {DATA_WIDTH{1'b1}};

   // Counter value on the edge that performs the final iteration.
   localparam int ITER_LAST = DATA_WIDTH - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/seq_divider_sub_borrow.sv
// Combinational W-bit subtractor with borrow in/out.
// It has the same shape as the datapath adder, with the sum replaced by a difference.
module sub_borrow
   import seq_divider_pkg::*;
#(
   parameter int W = DATA_WIDTH + 1
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic [W-1:0] diff,
   output logic         bout
);

   // The extra top bit of the widened difference is the borrow out.
   assign {bout, diff} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// A zero divisor is detected on the start edge and completes in one cycle.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   // Counter value of the final iteration, tracking WIDTH if it is overridden.
   localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(ITER_LAST - DATA_WIDTH + WIDTH);
   localparam logic [WIDTH-1:0] QUOT_ALL_ONES = {WIDTH{DIV_ZERO_QUOT[0]}};

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             div_by_zero_q, div_by_zero_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   r_shift_s;
   logic [WIDTH:0]   trial_s;
   logic             borrow_s;
   logic [WIDTH:0]   r_next_s;
   logic [WIDTH-1:0] q_next_s;
   logic             unused_r_msb_s;

   // The guard bit of R is always zero after a restoring step, so it never feeds the shift.
   assign unused_r_msb_s = r_q[WIDTH];

   assign r_shift_s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

   sub_borrow #(.W(WIDTH + 1)) u_sub (
      .a    (r_shift_s),
      .b    ({1'b0, d_q}),
      .bin  (1'b0),
      .diff (trial_s),
      .bout (borrow_s)
   );

   // One restoring step: keep the trial difference unless it borrowed.
   always_comb begin
      if (borrow_s) begin
         r_next_s = r_shift_s;
      end else begin
         r_next_s = trial_s;
      end
      q_next_s = {q_q[WIDTH-2:0], ~borrow_s};
   end

   // Next-state and next-output logic for the IDLE/CALC/DONE sequence.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      q_d           = q_q;
      d_d           = d_q;
      r_d           = r_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      div_by_zero_d = div_by_zero_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor == {WIDTH{1'b0}}) begin
                  quotient_d    = QUOT_ALL_ONES;
                  remainder_d   = dividend;
                  div_by_zero_d = 1'b1;
                  done_d        = 1'b1;
                  state_d       = DONE;
               end else begin
                  q_d     = dividend;
                  d_d     = divisor;
                  r_d     = {(WIDTH + 1){1'b0}};
                  cnt_d   = {CNT_W{1'b0}};
                  busy_d  = 1'b1;
                  state_d = CALC;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            r_d   = r_next_s;
            q_d   = q_next_s;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               quotient_d    = q_next_s;
               remainder_d   = r_next_s[WIDTH-1:0];
               div_by_zero_d = 1'b0;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               state_d       = DONE;
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs; reset aborts any running divide.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= {CNT_W{1'b0}};
         q_q           <= {WIDTH{1'b0}};
         d_q           <= {WIDTH{1'b0}};
         r_q           <= {(WIDTH + 1){1'b0}};
         quotient_q    <= {WIDTH{1'b0}};
         remainder_q   <= {WIDTH{1'b0}};
         div_by_zero_q <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         q_q           <= q_d;
         d_q           <= d_d;
         r_q           <= r_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         div_by_zero_q <= div_by_zero_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, abort by reset and a random sweep.
module tb_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        div_by_zero;

   int checks   = 0;
   int errors   = 0;
   int done_cnt = 0;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] r;
      logic        dbz;
   } exp_t;

   exp_t sb[$];

   seq_divider #(.WIDTH(16), .CNT_W(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Count every done pulse seen at the sampling edge.
   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      if (b == 16'd0) begin
         e.q   = 16'hFFFF;
         e.r   = a;
         e.dbz = 1'b1;
      end else begin
         e.q   = a / b;
         e.r   = a % b;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   task automatic wait_done(output int lat, output int busy_n,
                            input logic [15:0] prev_q, input bit hold_chk);
      bit seen;
      seen   = 1'b0;
      lat    = 0;
      busy_n = 0;
      while (!seen && lat < 40) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
         if (lat == 1) begin
            dividend = 16'($urandom);
            divisor  = 16'($urandom);
         end
         if (busy === 1'b1) busy_n++;
         if (hold_chk && lat == 8) check("hold_q_mid_calc", 32'(quotient), 32'(prev_q));
         if (done === 1'b1) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic compare_result();
      exp_t e;
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("quotient", 32'(quotient), 32'(e.q));
         check("remainder", 32'(remainder), 32'(e.r));
         check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit timing_chk);
      int          lat;
      int          bn;
      logic [15:0] prev;
      logic [31:0] sum;
      prev = quotient;
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      sb.push_back(model(a, b));
      wait_done(lat, bn, prev, timing_chk && (b != 16'd0));
      compare_result();
      if (b != 16'd0) begin
         sum = 32'(quotient) * 32'(b) + 32'(remainder);
         check("inv_q_times_d_plus_r", sum, 32'(a));
         check("inv_r_lt_d", 32'(remainder < b), 32'd1);
      end
      if (timing_chk) begin
         check("latency", 32'(lat), (b == 16'd0) ? 32'd1 : 32'd17);
         check("busy_cycles", 32'(bn), (b == 16'd0) ? 32'd0 : 32'd16);
      end
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   // Directed sequence followed by the random sweep.
   initial begin
      int          base;
      int          lat;
      int          bn;
      logic [15:0] a;
      logic [15:0] b;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = 16'd0;
      divisor  = 16'd0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_quotient", 32'(quotient), 32'd0);
      check("rst_remainder", 32'(remainder), 32'd0);
      check("rst_dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;

      run_op(16'd100, 16'd7, 1'b1);
      run_op(16'hFFFF, 16'd1, 1'b1);
      run_op(16'hFFFF, 16'hFFFF, 1'b1);
      run_op(16'd3, 16'd10, 1'b1);
      run_op(16'd5, 16'd0, 1'b1);

      // A second start while busy must be dropped.
      base = done_cnt;
      @(negedge clk);
      start    = 1'b1;
      dividend = 16'd1000;
      divisor  = 16'd3;
      sb.push_back(model(16'd1000, 16'd3));
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_before_restart", 32'(busy), 32'd1);
      start    = 1'b1;
      dividend = 16'd9;
      divisor  = 16'd2;
      wait_done(lat, bn, quotient, 1'b0);
      compare_result();
      repeat (20) @(negedge clk);
      check("single_done", 32'(done_cnt - base), 32'd1);
      check("hold_quotient", 32'(quotient), 32'd333);
      check("hold_remainder", 32'(remainder), 32'd1);

      // Reset in the middle of a divide aborts it.
      base = done_cnt;
      @(negedge clk);
      start    = 1'b1;
      dividend = 16'd50000;
      divisor  = 16'd123;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_quotient", 32'(quotient), 32'd0);
      check("abort_remainder", 32'(remainder), 32'd0);
      check("abort_dbz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("abort_no_done", 32'(done_cnt - base), 32'd0);
      run_op(16'd50000, 16'd123, 1'b1);

      // Random sweep with corner operands mixed in.
      base = done_cnt;
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         case (i % 10)
            0:       a = 16'd0;
            1:       b = 16'd0;
            2:       a = 16'hFFFF;
            3:       b = 16'hFFFF;
            4:       b = 16'd1;
            5:       b = 16'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(a, b, 1'b0);
      end
      repeat (2) @(negedge clk);
      check("sweep_done_count", 32'(done_cnt - base), 32'd2000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
